// File: rtl/move_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : move_arbiter
// Description : Turns keyboard make/break events for two players into
//               move (and optional bomb) commands for the map-update port.
//               Per-player held-key vectors, per-player cooldown, round-robin
//               grant between players, two-state request/acknowledge FSM.
//               Optional feature macro: BOMB_KEY_EN (adds bomb keys and the
//               o_move_bomb output).
// Revision    : 1.0 - initial release
// ============================================================================
module move_arbiter #(
  parameter int MOVE_PERIOD = 2500000,
  parameter int CNT_W       = 22
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_key_data,
  input  logic       i_key_valid,
  input  logic       i_key_break,
  output logic       o_move_req,
  output logic       o_move_player,
  output logic [1:0] o_move_dir,
`ifdef BOMB_KEY_EN
  output logic       o_move_bomb,
`endif
  input  logic       i_move_ack
);

  localparam logic [0:0]       c_idle   = 1'b0;
  localparam logic [0:0]       c_req    = 1'b1;
  localparam logic [CNT_W-1:0] c_reload = CNT_W'(MOVE_PERIOD - 1);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [1:0][3:0]       r_held;
  logic [1:0][CNT_W-1:0] r_cd;
  logic [1:0]            w_elig;
  logic [1:0]            w_bomb_pend;
  logic                  r_last_p2;
  logic                  r_move_player;
  logic [1:0]            r_move_dir;
  logic                  w_ack;
  logic                  w_grant;
  logic                  w_gnt_player;
  logic [1:0]            w_gnt_dir;
  logic                  w_mv_hit;
  logic                  w_mv_player;
  logic [1:0]            w_mv_bit;
  logic                  w_bomb_hit;
  logic                  w_bomb_player;

  // Direction priority among held keys: up > down > left > right.
  function automatic logic [1:0] f_prio(input logic [3:0] h);
    if (h[0])      return 2'd0;
    else if (h[1]) return 2'd1;
    else if (h[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Decode the ASCII key code into player / direction bit or bomb key.
  always_comb begin
    w_mv_hit      = 1'b0;
    w_mv_player   = 1'b0;
    w_mv_bit      = 2'd0;
    w_bomb_hit    = 1'b0;
    w_bomb_player = 1'b0;
    case (i_key_data)
      8'h57: begin w_mv_hit = 1'b1; w_mv_player = 1'b0; w_mv_bit = 2'd0; end
      8'h53: begin w_mv_hit = 1'b1; w_mv_player = 1'b0; w_mv_bit = 2'd1; end
      8'h41: begin w_mv_hit = 1'b1; w_mv_player = 1'b0; w_mv_bit = 2'd2; end
      8'h44: begin w_mv_hit = 1'b1; w_mv_player = 1'b0; w_mv_bit = 2'd3; end
      8'h49: begin w_mv_hit = 1'b1; w_mv_player = 1'b1; w_mv_bit = 2'd0; end
      8'h4B: begin w_mv_hit = 1'b1; w_mv_player = 1'b1; w_mv_bit = 2'd1; end
      8'h4A: begin w_mv_hit = 1'b1; w_mv_player = 1'b1; w_mv_bit = 2'd2; end
      8'h4C: begin w_mv_hit = 1'b1; w_mv_player = 1'b1; w_mv_bit = 2'd3; end
`ifdef BOMB_KEY_EN
      8'h46: begin w_bomb_hit = 1'b1; w_bomb_player = 1'b0; end
      8'h48: begin w_bomb_hit = 1'b1; w_bomb_player = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign w_ack = (r_state == c_req) && i_move_ack;

`ifdef BOMB_KEY_EN
  logic [1:0] r_bomb;
  logic       r_move_bomb;
  assign w_bomb_pend = r_bomb;
  assign o_move_bomb = r_move_bomb;
`else
  assign w_bomb_pend = 2'b00;
`endif

  generate
    for (genvar p = 0; p < 2; p++) begin : g_player
      // Held-key vector: make sets, break clears the decoded direction bit.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_held[p] <= 4'b0000;
        end else if (i_key_valid && w_mv_hit && (w_mv_player == 1'(p))) begin
          r_held[p][w_mv_bit] <= ~i_key_break;
        end
      end

      // Cooldown: reload on this player's handshake, else count down to 0.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cd[p] <= '0;
        end else if (w_ack && (r_move_player == 1'(p))) begin
          r_cd[p] <= c_reload;
        end else if (r_cd[p] != '0) begin
          r_cd[p] <= r_cd[p] - 1'b1;
        end
      end

`ifdef BOMB_KEY_EN
      // Bomb pending: cleared when its bomb command is acknowledged; a new make wins.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_bomb[p] <= 1'b0;
        end else begin
          if (w_ack && r_move_bomb && (r_move_player == 1'(p)))
            r_bomb[p] <= 1'b0;
          if (i_key_valid && w_bomb_hit && !i_key_break && (w_bomb_player == 1'(p)))
            r_bomb[p] <= 1'b1;
        end
      end
`endif

      assign w_elig[p] = (r_cd[p] == '0) && ((|r_held[p]) || w_bomb_pend[p]);
    end
  endgenerate

  // Round-robin choice: on a tie grant the player not granted last.
  assign w_gnt_player = (&w_elig) ? ~r_last_p2 : w_elig[1];
  assign w_gnt_dir    = f_prio(r_held[w_gnt_player]);
  assign w_grant      = (r_state == c_idle) && (|w_elig);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= c_idle;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: IDLE waits for an eligible player, REQ waits for ACK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (|w_elig)   w_state_nxt = c_req;
      c_req:   if (i_move_ack) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // FSM output: request is asserted for the whole REQ state.
  always_comb begin
    o_move_req = (r_state == c_req);
  end

  // Command fields are captured on entry to REQ and held until ACK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_move_player <= 1'b0;
      r_move_dir    <= 2'b00;
    end else if (w_grant) begin
      r_move_player <= w_gnt_player;
      r_move_dir    <= w_gnt_dir;
    end
  end

`ifdef BOMB_KEY_EN
  // A pending bomb outranks movement inside the granted player's command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_move_bomb <= 1'b0;
    else if (w_grant) r_move_bomb <= r_bomb[w_gnt_player];
  end
`endif

  // Round-robin pointer tracks the last acknowledged player (resets to player 2).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_last_p2 <= 1'b1;
    else if (w_ack) r_last_p2 <= r_move_player;
  end

  assign o_move_player = r_move_player;
  assign o_move_dir    = r_move_dir;

endmodule
`default_nettype wire

// File: tb/tb_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_arbiter
// Description : Directed testbench for move_arbiter (MOVE_PERIOD=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_break;
  logic       req;
  logic       player;
  logic [1:0] dir;
  logic       ack;
`ifdef BOMB_KEY_EN
  logic       bomb;
`endif

  int nvec  = 0;
  int nfail = 0;
  logic seen;

  move_arbiter #(.MOVE_PERIOD(4), .CNT_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_key_data    (key_data),
    .i_key_valid   (key_valid),
    .i_key_break   (key_break),
    .o_move_req    (req),
    .o_move_player (player),
    .o_move_dir    (dir),
`ifdef BOMB_KEY_EN
    .o_move_bomb   (bomb),
`endif
    .i_move_ack    (ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One key event lasting one cycle; returns in the following cycle.
  task automatic press(input logic [7:0] code, input logic brk);
    key_data  = code;
    key_break = brk;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_break = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_break = 1'b0;
    key_data  = 8'h00;
    ack       = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {5'b0, req, player, dir}, 8'h00);
`ifdef BOMB_KEY_EN
    chk("reset_bomb", {7'b0, bomb}, 8'h00);
`endif
    rst_n = 1'b1;
  endtask

  // Tick n cycles and report whether MOVE_REQ was ever seen high.
  task automatic watch(input int n, output logic any);
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      any = any | req;
    end
  endtask

  initial begin
    // ---- single player, cooldown spacing ----
    do_reset();
    press(8'h57, 1'b0);                       // c0 -> c1
    chk("A_c1_req", {7'b0, req}, 8'h00);
    tick();                                   // c2
    chk("A_c2_cmd", {4'b0, req, player, dir}, 8'h08);
    tick();                                   // c3
    chk("A_c3_req", {7'b0, req}, 8'h00);
    tick(); tick(); tick();                   // c6
    chk("A_c6_req", {7'b0, req}, 8'h00);
    tick();                                   // c7
    chk("A_c7_cmd", {4'b0, req, player, dir}, 8'h08);
    press(8'h57, 1'b1);                       // c7 -> c8 release
    watch(8, seen);
    chk("A_no_req_after_break", {7'b0, seen}, 8'h00);

    // ---- round robin with a true tie at c6 ----
    do_reset();
    press(8'h41, 1'b0);                       // c0 -> c1
    tick();                                   // c2
    chk("B_c2_p1_left", {4'b0, req, player, dir}, 8'h0A);
    tick(); tick(); tick();                   // c5
    press(8'h4C, 1'b0);                       // c5 -> c6
    chk("B_c6_req", {7'b0, req}, 8'h00);
    tick();                                   // c7
    chk("B_c7_p2_right", {4'b0, req, player, dir}, 8'h0F);
    tick(); tick();                           // c9
    chk("B_c9_p1_left", {4'b0, req, player, dir}, 8'h0A);
    tick(); tick(); tick();                   // c12
    chk("B_c12_p2_right", {4'b0, req, player, dir}, 8'h0F);
    tick(); tick();                           // c14
    chk("B_c14_p1_left", {4'b0, req, player, dir}, 8'h0A);

    // ---- held request without ACK, key released during REQ ----
    do_reset();
    ack = 1'b0;
    press(8'h57, 1'b0);                       // c0 -> c1
    tick();                                   // c2
    chk("C_c2_cmd", {4'b0, req, player, dir}, 8'h08);
    press(8'h57, 1'b1);                       // c2 -> c3
    for (int i = 0; i < 9; i++) begin         // c3 .. c11
      chk("C_stable", {4'b0, req, player, dir}, 8'h08);
      if (i < 8) tick();
    end
    ack = 1'b1;                               // accepted at end of c11
    tick();                                   // c12
    chk("C_after_ack", {7'b0, req}, 8'h00);
    watch(8, seen);
    chk("C_no_further_req", {7'b0, seen}, 8'h00);

    // ---- direction priority ----
    do_reset();
    press(8'h44, 1'b0);                       // c0 -> c1
    press(8'h53, 1'b0);                       // c1 -> c2
    chk("D_c2_right", {4'b0, req, player, dir}, 8'h0B);
    repeat (5) tick();                        // c7
    chk("D_c7_down_wins", {4'b0, req, player, dir}, 8'h09);
    press(8'h53, 1'b1);                       // c7 -> c8
    repeat (4) tick();                        // c12
    chk("D_c12_right", {4'b0, req, player, dir}, 8'h0B);
    press(8'h44, 1'b1);

    // ---- reset in the middle of REQ ----
    do_reset();
    ack = 1'b0;
    press(8'h57, 1'b0);                       // c0 -> c1
    tick();                                   // c2
    chk("E_c2_req", {7'b0, req}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("E_async_clear", {5'b0, req, player, dir}, 8'h00);
    tick();
    rst_n = 1'b1;
    ack   = 1'b1;
    watch(6, seen);
    chk("E_no_req_after_rst", {7'b0, seen}, 8'h00);

`ifdef BOMB_KEY_EN
    // ---- bomb then move for player 2 ----
    do_reset();
    press(8'h48, 1'b0);                       // c0 -> c1
    press(8'h49, 1'b0);                       // c1 -> c2
    chk("F_c2_bomb", {5'b0, req, player, bomb}, 8'h07);
    repeat (5) tick();                        // c7
    chk("F_c7_move_up", {3'b0, req, player, bomb, dir}, 8'h18);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/move_arbiter.md
MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 Parameter MOVE_PERIOD, default 2500000, per-player cooldown in CLK cycles between accepted commands (50 ms at 50 MHz); legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 22, cooldown counter width.
REQ-003 CLK  input  1  single system clock; all logic on posedge.
REQ-004 RSTn  input  1  asynchronous active-low reset.
REQ-005 KEY_DATA  input  8  ASCII code from keyboard decoder; sampled only when KEY_VALID=1.
REQ-006 KEY_VALID  input  1  one-cycle strobe, one key event per cycle.
REQ-007 KEY_BREAK  input  1  qualifies KEY_VALID: 0 = make (press), 1 = break (release).
REQ-008 MOVE_REQ  output  1  command request to the map-update port.
REQ-009 MOVE_PLAYER  output  1  0 = player 1, 1 = player 2.
REQ-010 MOVE_DIR  output  2  00 up, 01 down, 10 left, 11 right.
REQ-011 MOVE_ACK  input  1  map port accepts the command in the cycle where MOVE_REQ=1 and MOVE_ACK=1.
REQ-012 MOVE_BOMB  output  1  command is a bomb drop, not a move (present only with BOMB_KEY_EN).

Function
REQ-013 Key map: P1 0x57 up, 0x53 down, 0x41 left, 0x44 right; P2 0x49 up, 0x4B down, 0x4A left, 0x4C right; all other codes ignored.
REQ-014 Per-player 4-bit held vector: a make sets the bit and a break clears it, registered in the cycle after KEY_VALID.
REQ-015 Direction when several bits are held: up > down > left > right.
REQ-016 Per-player cooldown counter: loads MOVE_PERIOD-1 on that player's acknowledged handshake, then decrements to 0 and saturates.
REQ-017 A player is eligible when its cooldown is 0 and (any held bit is set or a bomb is pending).
REQ-018 FSM states: IDLE and REQ.
REQ-019 IDLE with at least one eligible player -> REQ next cycle; MOVE_REQ=1 one cycle after eligibility is registered.
REQ-020 Round-robin: if both players are eligible, grant the player that was not granted last; the pointer updates only on ACK.
REQ-021 On entry to REQ, MOVE_PLAYER, MOVE_DIR and MOVE_BOMB are latched and held stable until ACK, even if keys are released or changed.
REQ-022 REQ with MOVE_ACK=1 -> IDLE; MOVE_REQ=0 in the next cycle, the cooldown loads, and the granted player's bomb pending flag clears if MOVE_BOMB=1.
REQ-023 REQ with MOVE_ACK=0 -> stay in REQ indefinitely; no timeout.
REQ-024 MOVE_ACK while in IDLE is ignored.
REQ-025 Key events during REQ still update the held vectors; they affect only the next grant.
REQ-026 The non-granted player's cooldown keeps counting while the FSM is in REQ.
REQ-027 With MOVE_PERIOD=1, a held key produces a command every 2 cycles when MOVE_ACK is tied high.

Reset
REQ-028 RSTn=0 asynchronously forces: FSM=IDLE, MOVE_REQ=0, MOVE_PLAYER=0, MOVE_DIR=00, MOVE_BOMB=0, held vectors=0, bomb flags=0, cooldowns=0, RR pointer=player 2 (so player 1 wins the first tie).
REQ-029 Reset asserted in REQ abandons the command; there is no ACK obligation after release.
REQ-030 The first grant after reset release is possible 2 cycles after the first valid make.

Configuration
REQ-031 Macro BOMB_KEY_EN is defined: keys 0x46 (P1) and 0x48 (P2) set a per-player bomb pending flag on make (break ignored); MOVE_BOMB output exists.
REQ-032 A pending bomb takes priority over movement within that player's grant and reloads the cooldown on ACK like a move.
REQ-033 Macro BOMB_KEY_EN is undefined: the MOVE_BOMB port, the bomb flags and the codes 0x46/0x48 are absent or ignored; behaviour is otherwise identical.

Verification (bench MOVE_PERIOD=4, MOVE_ACK tied 1 unless stated)
REQ-034 Make 0x57 at cycle 0 -> MOVE_REQ=1 at cycle 2 with PLAYER=0, DIR=00; the next request comes at cycle 7 (4-cycle cooldown + 1).
REQ-035 P1 0x41 and P2 0x4C held, both eligible -> grants alternate P1 (DIR=10), P2 (DIR=11), P1, and so on.
REQ-036 MOVE_ACK=0 for 10 cycles and release 0x57 during REQ -> MOVE_REQ, PLAYER and DIR remain stable; one ACK then no further request.
REQ-037 Hold 0x53 and 0x44 -> DIR=01 (down wins); break 0x53 -> the next grant has DIR=11.
REQ-038 RSTn low mid-REQ -> MOVE_REQ=0 immediately, with no request after release until a new make.
REQ-039 BOMB_KEY_EN defined: P2 holds 0x49 and makes 0x48 -> a grant with MOVE_BOMB=1, PLAYER=1, then a move with DIR=00 after the cooldown.
